// File: rtl/tinyalu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tinyalu_arbiter
// Purpose  : Round-robin sharing of one TinyALU between two requesters,
//            with a watchdog that turns a hung operation into an error reply.
// Revision : 1.0 - initial release
// ============================================================================
module tinyalu_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        gnt_q, gnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] result_q, result_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        gnt_sel;
  logic [2:0]  sel_op;
  logic        sel_is_alu;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_result = 16'h0000;
    rsp_err    = 1'b0;
    alu_start  = 1'b0;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_op     = 3'b000;

    // A lone requester wins outright; contention is settled by rr_q.
    gnt_sel    = (req0_valid && req1_valid) ? rr_q : req1_valid;
    sel_op     = gnt_sel ? req1_op : req0_op;
    sel_is_alu = (sel_op != 3'b000) && (sel_op <= 3'b100);

    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~gnt_sel;
          req1_ready = gnt_sel;
          rr_d       = ~gnt_sel;
          gnt_d      = gnt_sel;
          a_d        = gnt_sel ? req1_a : req0_a;
          b_d        = gnt_sel ? req1_b : req0_b;
          op_d       = sel_op;
          cnt_d      = 8'h00;
          if (sel_is_alu) begin
            state_d = ST_BUSY;
          end else begin
            result_d = 16'h0000;
            err_d    = 1'b0;
            state_d  = ST_RESP;
          end
        end
      end

      ST_BUSY: begin
        alu_start = 1'b1;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_op    = op_q;
        cnt_d     = cnt_q + 8'h01;
        // done takes priority over a watchdog expiry in the same cycle
        if (alu_done) begin
          result_d = alu_result;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == C_TO_LAST) begin
          result_d = 16'h0000;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid = gnt_q;
        rsp_result = result_q;
        rsp_err    = err_q;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 3'b000;
      result_q <= 16'h0000;
      err_q    <= 1'b0;
      cnt_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinyalu_arbiter
// Purpose  : Directed self-checking bench for tinyalu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tinyalu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        alu_start;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;

  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  int          model_delay = 0;
  int          mcnt = 0;

  int          tests_run = 0;
  int          tests_failed = 0;

  assign alu_done = model_done | stray_done;

  always #5 clk = ~clk;

  tinyalu_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  // TinyALU model: done rises model_delay cycles after start first goes high.
  always @(negedge clk) begin
    if (alu_start) begin
      model_done = (mcnt == model_delay);
      mcnt = mcnt + 1;
      case (alu_op)
        3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
        3'b010:  alu_result = {8'h00, alu_a & alu_b};
        3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
        3'b100:  alu_result = alu_a * alu_b;
        default: alu_result = 16'h0000;
      endcase
    end else begin
      model_done = 1'b0;
      mcnt = 0;
      alu_result = 16'hDEAD;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from a single requester; exp_cycles counts cycles from
  // the one after accept up to and including the response cycle.
  task automatic run_op(input string tag, input logic who, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op, input int delay,
                        input logic [15:0] exp_res, input logic exp_err,
                        input int exp_cycles);
    bit got, stable, start_seen;
    int k;
    got = 1'b0; stable = 1'b1; start_seen = 1'b0; k = 0;
    @(negedge clk);
    model_delay = delay;
    if (!who) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    #1;
    check({tag, "_ready"}, 64'({req1_ready, req0_ready}), who ? 64'd2 : 64'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      k++;
      if (rsp0_valid || rsp1_valid) begin
        got = 1'b1;
        check({tag, "_route"}, 64'({rsp1_valid, rsp0_valid}), who ? 64'd2 : 64'd1);
        check({tag, "_result"}, 64'(rsp_result), 64'(exp_res));
        check({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        check({tag, "_start_in_rsp"}, 64'(alu_start), 64'd0);
        check({tag, "_latency"}, 64'(k), 64'(exp_cycles));
      end else if (alu_start) begin
        start_seen = 1'b1;
        if ({alu_a, alu_b, alu_op} !== {a, b, op}) stable = 1'b0;
      end
    end
    check({tag, "_got_rsp"}, 64'(got), 64'd1);
    check({tag, "_alu_stable"}, 64'(stable), 64'd1);
    check({tag, "_start_seen"}, 64'(start_seen), (exp_cycles > 1) ? 64'd1 : 64'd0);
    @(negedge clk);
    #1;
    check({tag, "_back_idle"}, 64'({busy, rsp0_valid, rsp1_valid}), 64'd0);
  endtask

  int  grants[$];
  int  n_rsp0, n_rsp1, n_g0, n_g1;
  bit  quiet;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'b000;
    req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_start, busy,
               rsp_result, alu_a, alu_b, alu_op}), 64'd0);
    reset = 1'b0;

    run_op("add",       1'b0, 8'h12, 8'h34, 3'b001, 1,    16'h0046, 1'b0, 3);
    run_op("mul",       1'b1, 8'hFF, 8'hFF, 3'b100, 3,    16'hFE01, 1'b0, 5);
    run_op("noop0",     1'b0, 8'h55, 8'h66, 3'b000, 0,    16'h0000, 1'b0, 1);
    run_op("noop7",     1'b0, 8'h77, 8'h88, 3'b111, 0,    16'h0000, 1'b0, 1);
    run_op("timeout",   1'b0, 8'h03, 8'h04, 3'b001, 1000, 16'h0000, 1'b1, 17);
    run_op("done_last", 1'b1, 8'h80, 8'h80, 3'b001, 15,   16'h0100, 1'b0, 17);

    // Reset in the middle of a hung multiply: rr was left pointing at 1.
    run_op("and_pre",   1'b0, 8'hF0, 8'h3C, 3'b010, 0,    16'h0030, 1'b0, 2);
    @(negedge clk);
    model_delay = 1000;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h10; req0_op = 3'b100;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midop_busy", 64'({busy, alu_start}), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midop_reset_outputs",
          64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_start, busy,
               rsp_result, alu_a, alu_b, alu_op}), 64'd0);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid || alu_start || busy) quiet = 1'b0;
    end
    check("midop_no_rsp", 64'(quiet), 64'd1);

    // Contention: both hold valid; first grant must go to 0 after reset.
    @(negedge clk);
    model_delay = 0;
    req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hF0; req0_op = 3'b011;
    req1_valid = 1'b1; req1_a = 8'hA5; req1_b = 8'h0F; req1_op = 3'b011;
    n_rsp0 = 0; n_rsp1 = 0;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp0_valid) begin n_rsp0++; check("arb_rsp0_result", 64'(rsp_result), 64'h00FF); end
      if (rsp1_valid) begin n_rsp1++; check("arb_rsp1_result", 64'(rsp_result), 64'h00AA); end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rsp0_valid) begin n_rsp0++; check("arb_rsp0_result", 64'(rsp_result), 64'h00FF); end
      if (rsp1_valid) begin n_rsp1++; check("arb_rsp1_result", 64'(rsp_result), 64'h00AA); end
      @(negedge clk);
    end
    check("arb_grant_count", 64'(grants.size()), 64'd6);
    n_g0 = 0; n_g1 = 0;
    for (int i = 0; i < grants.size(); i++) begin
      check($sformatf("arb_grant_%0d", i), 64'(grants[i]), 64'(i % 2));
      if (grants[i] == 0) n_g0++; else n_g1++;
    end
    check("arb_rsp0_count", 64'(n_rsp0), 64'(n_g0));
    check("arb_rsp1_count", 64'(n_rsp1), 64'(n_g1));

    // Stray done while idle must be ignored.
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rsp0_valid || rsp1_valid || busy) quiet = 1'b0;
      @(negedge clk);
    end
    check("stray_done_ignored", 64'(quiet), 64'd1);

    run_op("add_post",  1'b0, 8'hFF, 8'h01, 3'b001, 2,    16'h0100, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire

// File: doc/tinyalu_arbiter.md
# tinyalu_arbiter

Shares one TinyALU between two independent requesters. It accepts an operation from one requester at a time using round-robin arbitration, and holds the ALU start/operand/op lines stable until the ALU asserts done. It then returns the 16-bit result to the requester that issued the operation, as a one-cycle response pulse. A watchdog converts a hung ALU operation into an error response, so that neither requester stalls forever.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of BUSY cycles without `alu_done` before an error response is returned (legal range 2..255).
- `clk` in, 1: sole clock; all logic on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` in, 1: requester has an operation pending.
- `req0_ready`, `req1_ready` out, 1: operation accepted this cycle; transfer occurs when valid && ready.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in, 8: operands.
- `req0_op`, `req1_op` in, 3: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101–111 are treated as no_op.
- `rsp0_valid`, `rsp1_valid` out, 1: one-cycle response pulse. There is no backpressure.
- `rsp_result` out, 16: result, valid with either `rspN_valid`.
- `rsp_err` out, 1: timeout error, valid with either `rspN_valid`.
- `alu_start` out, 1: TinyALU start.
- `alu_a`, `alu_b` out, 8: TinyALU operands.
- `alu_op` out, 3: TinyALU op.
- `alu_done` in, 1: TinyALU done.
- `alu_result` in, 16: TinyALU result.
- `busy` out, 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, BUSY, RESP.
- **IDLE:**
  - Grant `g` is the requester with valid high. If both are valid, grant goes to the requester indicated by the round-robin pointer `rr`.
  - `reqg_ready` is asserted combinationally in the same cycle; the other ready is held at 0.
  - On transfer: latch a/b/op into registers, set `rr` to the other requester, record `g`.
  - A non-noop op goes to BUSY. A no_op (or reserved op) goes directly to RESP with result 0 and err 0; the ALU is never started.
- **BUSY:**
  - `alu_start` = 1; `alu_a`/`alu_b`/`alu_op` are driven from the latched registers and stay stable for the whole state.
  - Watchdog counter is cleared on entry and increments each BUSY cycle.
  - `alu_done` = 1: capture `alu_result`, err = 0, go to RESP.
  - Counter reaches `TIMEOUT_CYCLES` without done: result = 0, err = 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP:**
  - `alu_start` = 0; `rspg_valid` = 1 for exactly this cycle; `rsp_result`/`rsp_err` are driven from the captured registers.
  - Always returns to IDLE. No request is accepted in RESP, which guarantees at least one start-low cycle between ALU operations.
- `alu_done` sampled outside BUSY is ignored.
- A requester may drop valid before ready without penalty; `rr` changes only on transfer.
- Only one operation is ever outstanding.

## Timing
- **Reset values:** state IDLE, `rr` = 0, all ready/rsp_valid/alu_start/busy/rsp_err = 0, `rsp_result` = 0, `alu_a`/`alu_b`/`alu_op` = 0.
- Reset asserted mid-operation aborts immediately. No response is issued, and `alu_start` is 0 in the cycle after the reset edge.
- **ALU op latency:** accept in cycle T; `alu_start` is high from T+1. If `alu_done` is sampled at edge E, the response appears in the cycle after E and start falls in that same cycle.
- **No_op latency:** accept in T, response in T+1.
- **Throughput:** at most one accept every 3 cycles for ALU ops (IDLE → BUSY → RESP); 2 cycles for no_op.
- **Timeout:** error response in the cycle after the `TIMEOUT_CYCLES`-th BUSY cycle.

## Test plan
- Basic add: after reset, req0 add a = 8'h12, b = 8'h34; ALU model raises done 1 cycle after start. Expect `rsp0_valid` pulse, `rsp_result` = 16'h0046, `rsp_err` = 0, `rsp1_valid` never asserted.
- Multiply: req1 mul a = 8'hFF, b = 8'hFF; ALU model raises done 3 cycles after start. Expect `rsp1_valid` with 16'hFE01; `alu_a`/`alu_b`/`alu_op` stable throughout BUSY; `alu_start` low in the response cycle.
- Arbitration: both requesters hold valid continuously with distinct xor ops. Expect grants to alternate 0, 1, 0, 1 starting from requester 0 after reset, and every response routed to its issuer.
- No_op: req0 op = 000. Expect `alu_start` never rises, and `rsp0_valid` the cycle after accept with result 0 and err 0. Repeat with op = 3'b111: same response.
- Timeout: ALU model never asserts done, `TIMEOUT_CYCLES` = 16. Expect an error response with `rsp_err` = 1 and result 0 after 16 BUSY cycles, then IDLE. With done first raised in the 16th BUSY cycle, expect a normal result with err 0.
- Reset mid-op: assert reset during BUSY of a mul. Expect no response, all outputs 0 on the next cycle, `rr` = 0; a fresh req0 add then completes normally. A stray `alu_done` pulse in IDLE produces no response.
